// File: rtl/tlb_pkg.sv
// Shared types and width helpers for the associative TLB.
// Entry field widths come from the package defaults below; retune them here for other address maps.
package tlb_pkg;

    localparam int TLB_VA_W      = 32;
    localparam int TLB_PA_W      = 32;
    localparam int TLB_PAGE_BITS = 12;
    localparam int TLB_VPN_W     = TLB_VA_W - TLB_PAGE_BITS;
    localparam int TLB_PPN_W     = TLB_PA_W - TLB_PAGE_BITS;

    typedef enum logic [0:0] {
        TLB_IDLE = 1'b0,
        TLB_MISS = 1'b1
    } tlb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TLB_VPN_W-1:0] vpn;
        logic [TLB_PPN_W-1:0] ppn;
        logic                 writable;
        logic                 user;
    } tlb_entry_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int vpn_width(input int va_w, input int page_bits);
        return va_w - page_bits;
    endfunction

    function automatic int ppn_width(input int pa_w, input int page_bits);
        return pa_w - page_bits;
    endfunction

endpackage

// File: rtl/tlb_assoc_if.sv
// Lookup, response, fill, invalidate and flush signals between the TLB and its clients.
interface tlb_assoc_if #(
    parameter int VA_W      = 32,
    parameter int PA_W      = 32,
    parameter int PAGE_BITS = 12
);
    localparam int VPN_W = VA_W - PAGE_BITS;
    localparam int PPN_W = PA_W - PAGE_BITS;

    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [VA_W-1:0]  req_addr;
    logic             req_write;
    logic             supervisor_mode;
    logic             resp_valid;
    logic [PA_W-1:0]  resp_paddr;
    logic             resp_miss;
    logic             resp_fault;
    logic             fill_valid;
    logic [VPN_W-1:0] fill_vpn;
    logic [PPN_W-1:0] fill_ppn;
    logic             fill_writable;
    logic             fill_user;
    logic             inval_valid;
    logic [VPN_W-1:0] inval_vpn;

    modport master (
        output flush, req_valid, req_addr, req_write, supervisor_mode,
        output fill_valid, fill_vpn, fill_ppn, fill_writable, fill_user,
        output inval_valid, inval_vpn,
        input  req_ready, resp_valid, resp_paddr, resp_miss, resp_fault
    );

    modport slave (
        input  flush, req_valid, req_addr, req_write, supervisor_mode,
        input  fill_valid, fill_vpn, fill_ppn, fill_writable, fill_user,
        input  inval_valid, inval_vpn,
        output req_ready, resp_valid, resp_paddr, resp_miss, resp_fault
    );
endinterface

// File: rtl/tlb_lru.sv
// True-LRU age tracker: ages stay a permutation of 0..ENTRIES-1, age 0 is most recent.
// Two touches per cycle are applied in order: lookup hit first, then fill.
module tlb_lru
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 8,
    localparam int IDX_W  = idx_width(ENTRIES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               touch_a_en,
    input  logic [IDX_W-1:0]   touch_a_idx,
    input  logic               touch_b_en,
    input  logic [IDX_W-1:0]   touch_b_idx,
    input  logic [ENTRIES-1:0] valid_vec,
    output logic [IDX_W-1:0]   victim_idx
);

    logic [IDX_W-1:0] age_reg  [ENTRIES];
    logic [IDX_W-1:0] age_mid  [ENTRIES];
    logic [IDX_W-1:0] age_next [ENTRIES];
    logic [IDX_W-1:0] a_age, b_age;

    always_comb begin
        a_age = age_reg[touch_a_idx];
        for (int i = 0; i < ENTRIES; i++) begin
            age_mid[i] = age_reg[i];
            if (touch_a_en) begin
                if (touch_a_idx == IDX_W'(i))
                    age_mid[i] = '0;
                else if (age_reg[i] < a_age)
                    age_mid[i] = age_reg[i] + 1'b1;
            end
        end
        b_age = age_mid[touch_b_idx];
        for (int i = 0; i < ENTRIES; i++) begin
            age_next[i] = age_mid[i];
            if (touch_b_en) begin
                if (touch_b_idx == IDX_W'(i))
                    age_next[i] = '0;
                else if (age_mid[i] < b_age)
                    age_next[i] = age_mid[i] + 1'b1;
            end
        end
    end

    // Victim prefers the lowest-index invalid slot, falling back to the oldest entry.
    always_comb begin
        logic found_invalid;
        found_invalid = 1'b0;
        victim_idx    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (age_reg[i] == IDX_W'(ENTRIES - 1))
                victim_idx = IDX_W'(i);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                found_invalid = 1'b1;
                victim_idx    = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset)
                age_reg[i] <= IDX_W'(i);
            else
                age_reg[i] <= age_next[i];
        end
    end

endmodule

// File: rtl/tlb_assoc.sv
// Fully-associative TLB: parallel VPN compare, permission check, miss-blocking FSM,
// single-entry invalidate, flush, and registered one-cycle response.
module tlb_assoc
    import tlb_pkg::*;
#(
    parameter int ENTRIES   = 8,
    parameter int VA_W      = TLB_VA_W,
    parameter int PA_W      = TLB_PA_W,
    parameter int PAGE_BITS = TLB_PAGE_BITS
) (
    input logic         clk,
    input logic         reset,
    tlb_assoc_if.slave  bus
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int VPN_W = vpn_width(VA_W, PAGE_BITS);

    tlb_entry_t       entry_reg [ENTRIES];
    tlb_state_t       state_reg;
    logic             req_ready_reg;
    logic             resp_valid_reg, resp_miss_reg, resp_fault_reg;
    logic [PA_W-1:0]  resp_paddr_reg;

    logic [VPN_W-1:0]   req_vpn;
    logic [ENTRIES-1:0] hit_vec, fill_match_vec, inval_match_vec, valid_vec;
    logic [IDX_W-1:0]   hit_idx, fill_match_idx, victim_idx, fill_idx;
    logic               any_hit, fill_hit, accept, lookup_live, perm_fault;
    logic               touch_hit_en, touch_fill_en;
    logic [PA_W-1:0]    sup_paddr, hit_paddr;

    assign req_vpn = bus.req_addr[VA_W-1:PAGE_BITS];

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
            assign valid_vec[gi]       = entry_reg[gi].valid;
            assign hit_vec[gi]         = entry_reg[gi].valid && (entry_reg[gi].vpn == req_vpn);
            assign fill_match_vec[gi]  = entry_reg[gi].valid && (entry_reg[gi].vpn == bus.fill_vpn);
            assign inval_match_vec[gi] = entry_reg[gi].valid && (entry_reg[gi].vpn == bus.inval_vpn);
        end
    endgenerate

    // Match vectors are one-hot at most, so OR-encoding yields the index.
    always_comb begin
        hit_idx        = '0;
        fill_match_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (hit_vec[i])        hit_idx        = hit_idx | IDX_W'(i);
            if (fill_match_vec[i]) fill_match_idx = fill_match_idx | IDX_W'(i);
        end
    end

    assign any_hit     = |hit_vec;
    assign fill_hit    = |fill_match_vec;
    assign fill_idx    = fill_hit ? fill_match_idx : victim_idx;
    assign accept      = bus.req_valid && req_ready_reg;
    assign lookup_live = accept && !bus.flush;
    assign perm_fault  = !entry_reg[hit_idx].user || (bus.req_write && !entry_reg[hit_idx].writable);
    assign hit_paddr   = {entry_reg[hit_idx].ppn, bus.req_addr[PAGE_BITS-1:0]};

    assign touch_hit_en  = lookup_live && !bus.supervisor_mode && any_hit && !perm_fault;
    assign touch_fill_en = bus.fill_valid && !bus.flush;

    generate
        if (PA_W <= VA_W) begin : g_sup_trunc
            assign sup_paddr = bus.req_addr[PA_W-1:0];
        end else begin : g_sup_ext
            assign sup_paddr = {{(PA_W - VA_W){1'b0}}, bus.req_addr};
        end
    endgenerate

    tlb_lru #(.ENTRIES(ENTRIES)) u_lru (
        .clk         (clk),
        .reset       (reset),
        .touch_a_en  (touch_hit_en),
        .touch_a_idx (hit_idx),
        .touch_b_en  (touch_fill_en),
        .touch_b_idx (fill_idx),
        .valid_vec   (valid_vec),
        .victim_idx  (victim_idx)
    );

    // Inval is applied before fill so a same-VPN pair leaves the freshly filled entry valid.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int i = 0; i < ENTRIES; i++)
                entry_reg[i].valid <= 1'b0;
        end else begin
            if (bus.inval_valid) begin
                for (int i = 0; i < ENTRIES; i++)
                    if (inval_match_vec[i])
                        entry_reg[i].valid <= 1'b0;
            end
            if (bus.fill_valid) begin
                entry_reg[fill_idx] <= '{valid:    1'b1,
                                         vpn:      bus.fill_vpn,
                                         ppn:      bus.fill_ppn,
                                         writable: bus.fill_writable,
                                         user:     bus.fill_user};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= TLB_IDLE;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_miss_reg  <= 1'b0;
            resp_fault_reg <= 1'b0;
            resp_paddr_reg <= '0;
        end else begin
            resp_valid_reg <= lookup_live;
            resp_miss_reg  <= 1'b0;
            resp_fault_reg <= 1'b0;
            resp_paddr_reg <= '0;
            if (lookup_live) begin
                if (bus.supervisor_mode)
                    resp_paddr_reg <= sup_paddr;
                else if (!any_hit)
                    resp_miss_reg <= 1'b1;
                else if (perm_fault)
                    resp_fault_reg <= 1'b1;
                else
                    resp_paddr_reg <= hit_paddr;
            end
            case (state_reg)
                TLB_IDLE: begin
                    if (lookup_live && !bus.supervisor_mode && !any_hit && !bus.fill_valid) begin
                        state_reg     <= TLB_MISS;
                        req_ready_reg <= 1'b0;
                    end
                end
                TLB_MISS: begin
                    if (bus.fill_valid || bus.flush) begin
                        state_reg     <= TLB_IDLE;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= TLB_IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_miss  = resp_miss_reg;
    assign bus.resp_fault = resp_fault_reg;
    assign bus.resp_paddr = resp_paddr_reg;

endmodule

// File: tb/tb_tlb_assoc.sv
// Directed plus random bench for tlb_assoc against a recency-list reference model.
module tb_tlb_assoc;

    localparam int ENTRIES   = 4;
    localparam int VA_W      = 32;
    localparam int PA_W      = 32;
    localparam int PAGE_BITS = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tlb_assoc_if #(.VA_W(VA_W), .PA_W(PA_W), .PAGE_BITS(PAGE_BITS)) bus ();

    tlb_assoc #(.ENTRIES(ENTRIES), .VA_W(VA_W), .PA_W(PA_W), .PAGE_BITS(PAGE_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: entry contents plus a most-recent-first list of entry indices.
    bit          m_valid [ENTRIES];
    logic [19:0] m_vpn   [ENTRIES];
    logic [19:0] m_ppn   [ENTRIES];
    bit          m_w     [ENTRIES];
    bit          m_u     [ENTRIES];
    int          lru_q   [$];
    bit          m_ready;

    bit          e_rv, e_miss, e_fault;
    logic [31:0] e_paddr;

    function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic void model_reset();
        lru_q.delete();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            lru_q.push_back(i);
        end
        m_ready = 1'b1;
    endfunction

    function automatic void touch_q(int idx);
        for (int p = 0; p < lru_q.size(); p++) begin
            if (lru_q[p] == idx) begin
                lru_q.delete(p);
                break;
            end
        end
        lru_q.push_front(idx);
    endfunction

    function automatic void model_cycle();
        bit          acc   = bus.req_valid && m_ready;
        bit          clean = 1'b0;
        bit          lmiss = 1'b0;
        int          h     = -1;
        int          tgt   = -1;
        int          inv   = -1;
        logic [19:0] rvpn  = bus.req_addr[31:12];
        e_rv = 1'b0; e_miss = 1'b0; e_fault = 1'b0; e_paddr = '0;
        if (acc && !bus.flush) begin
            e_rv = 1'b1;
            if (bus.supervisor_mode) begin
                e_paddr = bus.req_addr;
            end else begin
                for (int i = 0; i < ENTRIES; i++)
                    if (m_valid[i] && m_vpn[i] == rvpn) h = i;
                if (h < 0) begin
                    e_miss = 1'b1;
                    lmiss  = 1'b1;
                end else if (!m_u[h] || (bus.req_write && !m_w[h])) begin
                    e_fault = 1'b1;
                end else begin
                    e_paddr = {m_ppn[h], bus.req_addr[11:0]};
                    clean   = 1'b1;
                end
            end
        end
        if (bus.fill_valid) begin
            for (int i = 0; i < ENTRIES; i++)
                if (m_valid[i] && m_vpn[i] == bus.fill_vpn) tgt = i;
            for (int i = ENTRIES - 1; i >= 0; i--)
                if (!m_valid[i]) inv = i;
            if (tgt < 0) tgt = (inv >= 0) ? inv : lru_q[$];
        end
        if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            m_ready = 1'b1;
        end else begin
            if (bus.inval_valid)
                for (int i = 0; i < ENTRIES; i++)
                    if (m_valid[i] && m_vpn[i] == bus.inval_vpn) m_valid[i] = 1'b0;
            if (clean) touch_q(h);
            if (bus.fill_valid) begin
                m_valid[tgt] = 1'b1;
                m_vpn[tgt]   = bus.fill_vpn;
                m_ppn[tgt]   = bus.fill_ppn;
                m_w[tgt]     = bus.fill_writable;
                m_u[tgt]     = bus.fill_user;
                touch_q(tgt);
            end
            if (m_ready && lmiss && !bus.fill_valid) m_ready = 1'b0;
            else if (!m_ready && bus.fill_valid)    m_ready = 1'b1;
        end
    endfunction

    function automatic void check_ages();
        logic [31:0] obs  = '0;
        logic [31:0] exp  = '0;
        logic [31:0] seen = '0;
        for (int p = 0; p < lru_q.size(); p++)
            exp[8*lru_q[p] +: 8] = 8'(p);
        for (int i = 0; i < ENTRIES; i++) begin
            obs[8*i +: 8] = 8'(dut.u_lru.age_reg[i]);
            seen[dut.u_lru.age_reg[i]] = 1'b1;
        end
        check("age_perm", seen, 32'h0000_000F);
        check("ages", obs, exp);
    endfunction

    task automatic clear_inputs();
        bus.flush = 0; bus.req_valid = 0; bus.req_addr = '0; bus.req_write = 0;
        bus.supervisor_mode = 0; bus.fill_valid = 0; bus.fill_vpn = '0; bus.fill_ppn = '0;
        bus.fill_writable = 0; bus.fill_user = 0; bus.inval_valid = 0; bus.inval_vpn = '0;
    endtask

    task automatic set_req(logic [31:0] addr, bit wr, bit sup);
        bus.req_valid = 1; bus.req_addr = addr; bus.req_write = wr; bus.supervisor_mode = sup;
    endtask

    task automatic set_fill(logic [19:0] vpn, logic [19:0] ppn, bit w, bit u);
        bus.fill_valid = 1; bus.fill_vpn = vpn; bus.fill_ppn = ppn;
        bus.fill_writable = w; bus.fill_user = u;
    endtask

    task automatic set_inval(logic [19:0] vpn);
        bus.inval_valid = 1; bus.inval_vpn = vpn;
    endtask

    task automatic tick(string name);
        model_cycle();
        @(posedge clk);
        #1;
        check({name, ".resp_valid"}, 32'(bus.resp_valid), 32'(e_rv));
        check({name, ".resp_miss"},  32'(bus.resp_miss),  32'(e_miss));
        check({name, ".resp_fault"}, 32'(bus.resp_fault), 32'(e_fault));
        check({name, ".resp_paddr"}, bus.resp_paddr, e_paddr);
        check({name, ".req_ready"},  32'(bus.req_ready),  32'(m_ready));
        check_ages();
        $display("txn %-14s rv=%0b miss=%0b fault=%0b paddr=%08h ready=%0b",
                 name, bus.resp_valid, bus.resp_miss, bus.resp_fault, bus.resp_paddr, bus.req_ready);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("reset.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset.resp_miss",  32'(bus.resp_miss),  32'd0);
        check("reset.resp_fault", 32'(bus.resp_fault), 32'd0);
        check("reset.resp_paddr", bus.resp_paddr, 32'd0);
        check("reset.req_ready",  32'(bus.req_ready), 32'd1);
        check_ages();

        set_req(32'h0000_5123, 0, 0);          tick("miss5");
        check("miss5.ready_low", 32'(bus.req_ready), 32'd0);
        set_fill(20'h00005, 20'h0000A, 1, 1);  tick("fill5");
        check("fill5.ready_high", 32'(bus.req_ready), 32'd1);
        set_req(32'h0000_5123, 0, 0);          tick("hit5");
        check("hit5.paddr", bus.resp_paddr, 32'h0000_A123);

        bus.flush = 1;                         tick("flush0");
        for (int v = 1; v <= 4; v++) begin
            set_fill(20'(v), 20'(v + 16'h100), 1, 1); tick("fill_n");
        end
        for (int v = 1; v <= 3; v++) begin
            set_req({20'(v), 12'h010}, 0, 0); tick("touch_n");
        end
        set_fill(20'h00005, 20'h00105, 1, 1);  tick("fill5b");
        set_req(32'h0000_1000, 0, 0);          tick("hit1");
        check("hit1.paddr", bus.resp_paddr, 32'h0010_1000);
        set_req(32'h0000_4000, 0, 0);          tick("evicted4");
        check("evicted4.miss", 32'(bus.resp_miss), 32'd1);

        set_fill(20'h00007, 20'h00077, 0, 1);  tick("fill7ro");
        set_req(32'h0000_7abc, 1, 0);          tick("wr7");
        check("wr7.fault", 32'(bus.resp_fault), 32'd1);
        set_req(32'h0000_7abc, 0, 0);          tick("rd7");
        check("rd7.paddr", bus.resp_paddr, 32'h0007_7abc);
        set_fill(20'h00008, 20'h00088, 1, 0);  tick("fill8sup");
        set_req(32'h0000_8004, 0, 0);          tick("rd8");
        check("rd8.fault", 32'(bus.resp_fault), 32'd1);
        set_req(32'h1234_5678, 0, 1);          tick("super");
        check("super.paddr", bus.resp_paddr, 32'h1234_5678);

        set_inval(20'h00005); set_req(32'h0000_5040, 0, 0); tick("inval_hit5");
        check("inval_hit5.paddr", bus.resp_paddr, 32'h0010_5040);
        set_req(32'h0000_5040, 0, 0);          tick("post_inval5");
        check("post_inval5.miss", 32'(bus.resp_miss), 32'd1);
        set_inval(20'h00005); set_fill(20'h00005, 20'h00055, 1, 1); tick("inval_fill5");
        set_req(32'h0000_5040, 0, 0);          tick("refilled5");
        check("refilled5.paddr", bus.resp_paddr, 32'h0005_5040);

        set_req(32'h0009_9000, 0, 0);          tick("miss99");
        bus.flush = 1;                         tick("flush_miss");
        check("flush_miss.ready", 32'(bus.req_ready), 32'd1);
        bus.flush = 1; set_req(32'h0000_1000, 0, 0); tick("flush_req");
        check("flush_req.no_resp", 32'(bus.resp_valid), 32'd0);
        set_req(32'h0000_1000, 0, 0);          tick("flushed1");
        check("flushed1.miss", 32'(bus.resp_miss), 32'd1);
        set_fill(20'h00001, 20'h00111, 1, 1);  tick("fill1a");
        set_fill(20'h00001, 20'h00222, 1, 1);  tick("fill1b");
        set_req(32'h0000_1abc, 0, 0);          tick("refill1");
        check("refill1.paddr", bus.resp_paddr, 32'h0022_2abc);

        for (int n = 0; n < 400; n++) begin
            if (m_ready && $urandom_range(0, 99) < 70)
                set_req({20'($urandom_range(1, 6)), 12'($urandom)},
                        1'($urandom_range(0, 1)), $urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < (m_ready ? 20 : 50))
                set_fill(20'($urandom_range(1, 6)), 20'($urandom), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 10)
                set_inval(20'($urandom_range(1, 6)));
            if ($urandom_range(0, 99) < 3)
                bus.flush = 1;
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlb_assoc.md
# tlb_assoc

Parametrised fully-associative translation buffer: the next-generation replacement for the fixed 4-entry instruction/data TLB. It translates user-mode virtual addresses to physical addresses with one-cycle registered latency and true-LRU replacement. It adds per-entry permissions (user, writable), a request/response handshake with miss blocking, single-entry invalidate, and flush. It sits between the fetch/memory stage address generation and the cache, with the miss handler driving the fill port.

## Interface
- ENTRIES, 8, number of entries; power of two, ≥2
- VA_W, 32, virtual address width
- PA_W, 32, physical address width
- PAGE_BITS, 12, page-offset width; VPN_W = VA_W-PAGE_BITS, PPN_W = PA_W-PAGE_BITS
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  invalidate all entries
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when req_valid && req_ready
- req_addr  in  VA_W  virtual address
- req_write  in  1  access is a store
- supervisor_mode  in  1  bypass translation
- resp_valid  out  1  one-cycle response pulse
- resp_paddr  out  PA_W  translated address; 0 on miss/fault
- resp_miss  out  1  no valid matching entry
- resp_fault  out  1  permission violation on hit
- fill_valid  in  1  write an entry
- fill_vpn  in  VPN_W; fill_ppn  in  PPN_W; fill_writable  in  1; fill_user  in  1
- inval_valid  in  1  invalidate entry matching inval_vpn
- inval_vpn  in  VPN_W

## Operation
- Reset: all valid=0, age[i]=i, FSM=IDLE; resp_valid/resp_miss/resp_fault=0, resp_paddr=0, req_ready=1.
- FSM: IDLE (req_ready=1), MISS (req_ready=0). IDLE→MISS on accepted miss without same-cycle fill_valid; MISS→IDLE on fill_valid or flush. No automatic replay: the requester re-issues.
- Supervisor request: resp_paddr = req_addr[PA_W-1:0] zero-extended or truncated, miss/fault=0, no LRU update.
- User request: compare the VPN against all valid entries. On hit: resp_paddr={ppn, offset}. Fault if entry.user=0, or if req_write && entry.writable=0. A fault gives resp_paddr=0 and no LRU touch. A clean hit touches the entry.
- Ages form a permutation of 0..ENTRIES-1 at all times, including over invalid entries. Touching entry i with age a increments every entry whose age is < a, and sets age[i]=0.
- Fill: if the VPN is already present (valid), overwrite that entry. Otherwise use the lowest-index invalid entry, else the entry with age ENTRIES-1. The written entry is touched and becomes valid.
- Invalidate: clears valid of the matching entry; ages unchanged; no match is a no-op.
- Flush: clears all valid, ages unchanged, FSM→IDLE, suppresses that cycle's response (resp_valid=0 next cycle).
- Same-cycle priority: flush > inval > fill. Inval and fill on the same VPN leave the entry valid with the fill data.
- A lookup always sees pre-edge contents. A lookup concurrent with a fill or inval of its VPN reports the old result.
- At most one entry ever matches a VPN (the fill-overwrite rule guarantees this).

## Timing
- Response exactly 1 cycle after acceptance; resp_* registered, held only for the resp_valid cycle, then 0.
- Fill/inval are visible to a lookup accepted the following cycle.
- Miss at edge N sets req_ready=0 from cycle N+1. A fill at edge M sets req_ready=1 from cycle M+1.
- A fill is accepted in any state.
- The requester must not assert req_valid while req_ready=0; such requests are ignored.

## Structure
- tlb_pkg holds tlb_entry_t (valid, vpn, ppn, writable, user), the FSM enum tlb_state_t, and width helper functions.
- Sub-module tlb_lru: age array, touch port, victim output (lowest invalid else oldest), with valid vector input.
- Top: entry array, parallel compare, FSM, response register.

## Test plan
- Reset, then user read 0x0000_5123 with ENTRIES=4 -> resp_miss=1, req_ready=0 next cycle; fill vpn 0x00005→ppn 0x00A, user=1, writable=1 -> req_ready=1; re-read -> resp_paddr=0x0000_A123.
- Fill vpn 1..4, touch 1,2,3, fill vpn 5 -> entry holding vpn 4 replaced; lookup vpn 4 misses, vpn 1 hits.
- Fill vpn 7 writable=0: write -> resp_fault=1, paddr 0; read -> hit. Fill vpn 8 user=0: user read -> fault. supervisor_mode read 0x1234_5678 -> paddr 0x1234_5678.
- Same cycle inval vpn 5 + lookup vpn 5 -> hit reported; next lookup misses. Inval+fill vpn 5 same cycle -> entry valid.
- Flush in MISS state -> req_ready=1 next cycle, all lookups miss, no resp_valid for the flushed cycle's request.
- Refill of an existing vpn with a new ppn -> single match, new ppn returned; ages remain a permutation (checked by assertion every cycle).
